// File: rtl/video_timing_gen.sv
// video_timing_gen: runtime-programmable raster counters, blank/sync decode, frame counter
// and counter-timed vertical/raster interrupts with shadow registers committed at frame end.
module video_timing_gen #(
  parameter int CW      = 9,
  parameter int INT_LEN = 64,
  parameter int FCW     = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clken,
  input  logic           cfg_we,
  input  logic [3:0]     cfg_addr,
  input  logic [CW-1:0]  cfg_data,
  input  logic           vint_en,
  input  logic           rint_en,
  output logic [CW-1:0]  hcnt,
  output logic [CW-1:0]  vcnt,
  output logic           hblank,
  output logic           vblank,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           csync_n,
  output logic           int_n,
  output logic           rint_active,
  output logic [FCW-1:0] frame_cnt,
  output logic           cfg_pending
);
  localparam int NREG = 14;
  localparam logic [CW-1:0] ILEN = CW'(INT_LEN);
  localparam logic [CW-1:0] DEFAULTS [NREG] = '{
    CW'(447), CW'(311), CW'(320), CW'(415), CW'(344), CW'(375), CW'(248),
    CW'(255), CW'(248), CW'(251), CW'(248), CW'(4),   CW'(0),   CW'(256)
  };
  logic [CW-1:0]  shadow_q [NREG];
  logic [CW-1:0]  act_q [NREG];
  logic [CW-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0]  vint_q, vint_d, rint_q, rint_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic           pend_q, pend_d;
  logic           hbl_q, hbl_d, vbl_q, vbl_d;
  logic           hs_q, hs_d, vs_q, vs_d, cs_q, cs_d;
  logic           cfg_wr, h_end, v_end, frame_end, vint_hit, rint_hit;
  function automatic logic in_rng(input logic [CW-1:0] x, input logic [CW-1:0] b,
                                  input logic [CW-1:0] e);
    return (x >= b) && (x <= e);
  endfunction
  assign cfg_wr    = cfg_we & (cfg_addr < 4'(NREG));
  assign h_end     = hcnt_q == act_q[0];
  assign v_end     = vcnt_q == act_q[1];
  assign frame_end = clken & h_end & v_end;
  assign vint_hit  = (vcnt_q == act_q[10]) & (hcnt_q == act_q[11]);
  assign rint_hit  = (vcnt_q == act_q[12]) & (hcnt_q == act_q[13]);
  always_comb begin
    hcnt_d  = clken ? (h_end ? '0 : hcnt_q + 1'b1) : hcnt_q;
    vcnt_d  = (clken & h_end) ? (v_end ? '0 : vcnt_q + 1'b1) : vcnt_q;
    frame_d = frame_end ? frame_q + 1'b1 : frame_q;
    pend_d  = cfg_wr | (pend_q & ~frame_end);
    hbl_d   = clken ? in_rng(hcnt_q, act_q[2], act_q[3]) : hbl_q;
    vbl_d   = clken ? in_rng(vcnt_q, act_q[6], act_q[7]) : vbl_q;
    hs_d    = clken ? in_rng(hcnt_q, act_q[4], act_q[5]) : hs_q;
    vs_d    = clken ? in_rng(vcnt_q, act_q[8], act_q[9]) : vs_q;
    cs_d    = clken ? (hs_d | vs_d) : cs_q;
    vint_d  = !vint_en ? '0 : !clken ? vint_q : vint_hit ? ILEN :
              (vint_q != '0) ? vint_q - 1'b1 : '0;
    rint_d  = !rint_en ? '0 : !clken ? rint_q : rint_hit ? ILEN :
              (rint_q != '0) ? rint_q - 1'b1 : '0;
  end
  // The commit reads shadow_q before this edge's write, so a write landing on
  // frame_end stays pending for one more frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= DEFAULTS;
      act_q    <= DEFAULTS;
    end else begin
      if (frame_end) act_q <= shadow_q;
      if (cfg_wr) shadow_q[cfg_addr] <= cfg_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
      pend_q  <= 1'b0;
      hbl_q   <= 1'b0;
      vbl_q   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      cs_q    <= 1'b0;
      vint_q  <= '0;
      rint_q  <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      hbl_q   <= hbl_d;
      vbl_q   <= vbl_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      cs_q    <= cs_d;
      vint_q  <= vint_d;
      rint_q  <= rint_d;
    end
  end
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hblank      = hbl_q;
  assign vblank      = vbl_q;
  assign hsync_n     = ~hs_q;
  assign vsync_n     = ~vs_q;
  assign csync_n     = ~cs_q;
  assign rint_active = rint_q != '0;
  assign int_n       = ~((vint_q != '0) | rint_active);
  assign frame_cnt   = frame_q;
  assign cfg_pending = pend_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: frame-position reference model checked every clock, plus
// table-driven sync-range vectors and hand sequences for commit and interrupt corners.
module tb_video_timing_gen;
  localparam int CW = 9, INT_LEN = 64, FCW = 5;
  logic clk = 0, rst = 1, clken = 0, cfg_we = 0, vint_en = 0, rint_en = 0;
  logic [3:0] cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [CW-1:0] hcnt, vcnt;
  logic hblank, vblank, hsync_n, vsync_n, csync_n, int_n, rint_active, cfg_pending;
  logic [FCW-1:0] frame_cnt;
  video_timing_gen #(.CW(CW), .INT_LEN(INT_LEN), .FCW(FCW)) dut (
    .clk(clk), .rst(rst), .clken(clken), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .vint_en(vint_en), .rint_en(rint_en), .hcnt(hcnt), .vcnt(vcnt),
    .hblank(hblank), .vblank(vblank), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .csync_n(csync_n), .int_n(int_n), .rint_active(rint_active), .frame_cnt(frame_cnt),
    .cfg_pending(cfg_pending)
  );
  always #5 clk = ~clk;
  localparam int DEF [14]   = '{447, 311, 320, 415, 344, 375, 248, 255, 248, 251, 248, 4, 0, 256};
  localparam int SMALL [14] = '{15, 9, 10, 13, 11, 12, 7, 9, 8, 8, 3, 2, 5, 6};
  typedef struct {int hb; int he; int hlo; int vb; int ve; int vlo;} vec_t;
  vec_t vecs [6];
  int errors = 0, checks = 0, cyc = 0;
  // Model: position within the frame in ticks, and ticks elapsed since each interrupt load.
  int m_sh [14], m_act [14];
  int m_pos, m_fr, m_vage, m_rage;
  bit m_pend, m_hb, m_vb, m_hs, m_vs;

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", n, cyc, got, exp);
      if (errors >= 50) finish_run();
    end
  endtask

  function automatic bit rng(int x, int b, int e);
    return x >= b && x <= e;
  endfunction

  task automatic model_step();
    int w, h, v;
    bit fe;
    if (rst) begin
      for (int i = 0; i < 14; i++) begin m_sh[i] = DEF[i]; m_act[i] = DEF[i]; end
      m_pos = 0; m_fr = 0; m_vage = INT_LEN; m_rage = INT_LEN; m_pend = 0;
      m_hb = 0; m_vb = 0; m_hs = 0; m_vs = 0;
      return;
    end
    w = m_act[0] + 1; h = m_pos % w; v = m_pos / w;
    fe = clken && h == m_act[0] && v == m_act[1];
    if (clken) begin
      m_hb = rng(h, m_act[2], m_act[3]); m_vb = rng(v, m_act[6], m_act[7]);
      m_hs = rng(h, m_act[4], m_act[5]); m_vs = rng(v, m_act[8], m_act[9]);
    end
    if (!vint_en) m_vage = INT_LEN;
    else if (clken) m_vage = (v == m_act[10] && h == m_act[11]) ? 0 : (m_vage < INT_LEN ? m_vage + 1 : INT_LEN);
    if (!rint_en) m_rage = INT_LEN;
    else if (clken) m_rage = (v == m_act[12] && h == m_act[13]) ? 0 : (m_rage < INT_LEN ? m_rage + 1 : INT_LEN);
    if (clken) m_pos = fe ? 0 : m_pos + 1;
    if (fe) begin
      m_fr = (m_fr + 1) % (1 << FCW); m_pend = 0;
      for (int i = 0; i < 14; i++) m_act[i] = m_sh[i];
    end
    if (cfg_we && cfg_addr < 14) begin m_sh[cfg_addr] = int'(cfg_data); m_pend = 1; end
  endtask

  task automatic tick();
    int w;
    bit va, ra;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    w = m_act[0] + 1;
    va = m_vage < INT_LEN; ra = m_rage < INT_LEN;
    check("hcnt", hcnt, m_pos % w);
    check("vcnt", vcnt, m_pos / w);
    check("hblank", hblank, m_hb);
    check("vblank", vblank, m_vb);
    check("hsync_n", hsync_n, !m_hs);
    check("vsync_n", vsync_n, !m_vs);
    check("csync_n", csync_n, !(m_hs || m_vs));
    check("int_n", int_n, !(va || ra));
    check("rint_active", rint_active, ra);
    check("frame_cnt", frame_cnt, m_fr);
    check("cfg_pending", cfg_pending, m_pend);
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1; cfg_addr = 4'(a); cfg_data = CW'(d);
    tick();
    cfg_we = 0;
  endtask

  task automatic wait_commit(input int bound);
    for (int k = 0; k < bound && cfg_pending; k++) tick();
    check("commit_timeout", cfg_pending, 0);
  endtask

  initial begin
    int hs_lo, vs_lo, cs_lo, int_lo, maxh, maxv, n, ph, pv;
    bit found;
    vecs[0] = '{4, 7, 4, 8, 8, 1};
    vecs[1] = '{5, 5, 1, 0, 9, 10};
    vecs[2] = '{7, 4, 0, 9, 8, 0};
    vecs[3] = '{0, 15, 16, 9, 9, 1};
    vecs[4] = '{14, 20, 2, 2, 3, 2};
    vecs[5] = '{16, 20, 0, 10, 12, 0};
    // Reset, including a write that must be ignored while rst is high.
    rst = 1; cfg_we = 1; cfg_addr = 4'd0; cfg_data = 9'd15;
    tick(); tick();
    cfg_we = 0;
    check("rst_hcnt", hcnt, 0);
    check("rst_vcnt", vcnt, 0);
    check("rst_frame", frame_cnt, 0);
    check("rst_flags", {hblank, vblank, hsync_n, vsync_n, csync_n, int_n, rint_active, cfg_pending}, 8'b0011_1100);
    // One full frame at the power-on timing; small timing is written mid-frame.
    rst = 0; clken = 1; vint_en = 1;
    hs_lo = 0; vs_lo = 0; cs_lo = 0; int_lo = 0; maxh = 0; maxv = 0;
    for (int i = 0; i < 448 * 312; i++) begin
      if (i >= 1000 && i < 1014) begin
        cfg_we = 1; cfg_addr = 4'(i - 1000); cfg_data = CW'(SMALL[i - 1000]);
      end else cfg_we = 0;
      tick();
      hs_lo += int'(!hsync_n); vs_lo += int'(!vsync_n); cs_lo += int'(!csync_n); int_lo += int'(!int_n);
      if (int'(hcnt) > maxh) maxh = int'(hcnt);
      if (int'(vcnt) > maxv) maxv = int'(vcnt);
      if (i == 1014) check("pend_mid_frame", cfg_pending, 1);
    end
    check("f1_hmax", maxh, 447);
    check("f1_vmax", maxv, 311);
    check("f1_hsync_lo", hs_lo, 32 * 312);
    check("f1_vsync_lo", vs_lo, 4 * 448);
    check("f1_csync_lo", cs_lo, 4 * 448 + 308 * 32);
    check("f1_int_lo", int_lo, INT_LEN);
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_committed", cfg_pending, 0);
    // Vertical interrupt start position, then enable drop with clken low.
    found = 0; ph = 0; pv = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      ph = int'(hcnt); pv = int'(vcnt);
      tick();
      found = !int_n;
    end
    check("vint_found", found, 1);
    check("vint_hpos", ph, 2);
    check("vint_line", pv, 3);
    for (int k = 0; k < 9; k++) begin tick(); check("vint_held", int_n, 0); end
    vint_en = 0; clken = 0;
    tick();
    check("vint_drop", int_n, 1);
    clken = 1; vint_en = 1;
    // Sync range vectors: inclusive, empty when begin>end, clipped by htotal/vtotal.
    foreach (vecs[j]) begin
      wr(4, vecs[j].hb); wr(5, vecs[j].he); wr(8, vecs[j].vb); wr(9, vecs[j].ve);
      wait_commit(400);
      hs_lo = 0; vs_lo = 0;
      for (int k = 0; k < 160; k++) begin
        tick();
        hs_lo += int'(!hsync_n); vs_lo += int'(!vsync_n);
      end
      check("vec_hsync_lo", hs_lo, vecs[j].hlo * 10);
      check("vec_vsync_lo", vs_lo, vecs[j].vlo * 16);
    end
    // Write on the exact frame_end edge: stays pending for one more whole frame.
    for (int k = 0; k < 400 && m_pos != 159; k++) tick();
    check("fe_align", m_pos, 159);
    wr(4, 3);
    check("fe_write_pending", cfg_pending, 1);
    n = 0;
    for (int k = 0; k < 400 && cfg_pending; k++) begin tick(); n++; end
    check("fe_write_commit_ticks", n, 160);
    // Raster interrupt coincident with the vertical one.
    wr(12, 3); wr(13, 2);
    wait_commit(400);
    rint_en = 1;
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      ph = int'(hcnt); pv = int'(vcnt);
      tick();
      found = rint_active;
    end
    check("rint_found", found, 1);
    check("rint_pos", {ph[7:0], pv[7:0]}, {8'd2, 8'd3});
    check("rint_int_n", int_n, 0);
    n = 1;
    for (int k = 0; k < 200 && rint_active; k++) begin tick(); n += int'(rint_active); end
    check("rint_len", n, INT_LEN);
    check("both_done", int_n, 1);
    wr(13, 500);
    wait_commit(400);
    n = 0;
    for (int k = 0; k < 400; k++) begin tick(); n += int'(rint_active); end
    check("rint_hpos_oob", n, 0);
    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      int a;
      clken = ($urandom % 4) != 0;
      if ($urandom % 64 == 0) vint_en = ~vint_en;
      if ($urandom % 64 == 0) rint_en = ~rint_en;
      a = int'($urandom % 16);
      cfg_we = ($urandom % 12) == 0;
      cfg_addr = 4'(a);
      cfg_data = a == 0 ? CW'($urandom_range(8, 31)) : a == 1 ? CW'($urandom_range(4, 15)) : CW'($urandom_range(0, 40));
      tick();
    end
    cfg_we = 0; clken = 1; vint_en = 1; rint_en = 0;
    for (int i = 0; i < 14; i++) wr(i, SMALL[i]);
    wait_commit(2000);
    // Reset mid-line with an interrupt running and a write pending.
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin tick(); found = !int_n; end
    check("pre_rst_int", found, 1);
    wr(3, 14);
    check("pre_rst_pending", cfg_pending, 1);
    check("pre_rst_int_low", int_n, 0);
    rst = 1;
    tick();
    check("rst2_hcnt", hcnt, 0);
    check("rst2_vcnt", vcnt, 0);
    check("rst2_frame", frame_cnt, 0);
    check("rst2_flags", {hblank, vblank, hsync_n, vsync_n, csync_n, int_n, rint_active, cfg_pending}, 8'b0011_1100);
    rst = 0;
    for (int k = 0; k < 100; k++) tick();
    check("rst2_default_h", hcnt, 100);
    check("rst2_default_v", vcnt, 0);
    finish_run();
  end
endmodule
